// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions (width, opcode encodings, legality check).
// Latency: n/a (types and constants only).
// Backpressure: n/a. Imported by the arbiter, its interface and the ALU.
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b1001;

  // One request as presented to the ALU.
  typedef struct packed {
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [ALU_CTRL_W-1:0] ctrl;
  } alu_req_t;

  // Contents of one per-client response slot.
  typedef struct packed {
    logic [XLEN-1:0] op;
    logic            zero;
    logic            err;
  } alu_rsp_t;

  // Opcodes are dense from ALU_ADD up to ALU_AND; everything above is unused.
  function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl <= ALU_AND);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response handshakes of both clients plus the ALU drive bus.
// Latency: n/a (wires only).
// Backpressure: valid/ready per request and per response channel.
// Ports: slave = arbiter side, master = clients + ALU side.
interface alu_share_arb_if;
  import alu_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [XLEN-1:0]       req0_a;
  logic [XLEN-1:0]       req0_b;
  logic [ALU_CTRL_W-1:0] req0_ctrl;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [XLEN-1:0]       req1_a;
  logic [XLEN-1:0]       req1_b;
  logic [ALU_CTRL_W-1:0] req1_ctrl;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [XLEN-1:0]       rsp0_op;
  logic                  rsp0_zero;
  logic                  rsp0_err;

  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [XLEN-1:0]       rsp1_op;
  logic                  rsp1_zero;
  logic                  rsp1_err;

  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]       alu_op;
  logic                  alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_op, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_op, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_op, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_op, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_op, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_op, alu_zero
  );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, one-hot grant, work-conserving.
// Latency: grant is combinational from eligible; prio updates on the grant edge.
// Backpressure: none of its own; ineligible clients are simply never granted.
// Ports: clk, rst (async active-high), eligible[1:0] in, grant[1:0] out.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

  // After a grant the other client gets priority: granting client 0 sets
  // prio to 1 and granting client 1 sets it to 0, i.e. prio <= grant[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant != 2'b00) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two clients, round-robin.
// Latency: request accepted at edge N -> response valid from edge N (one cycle).
// Backpressure: a client whose response slot is full and not being drained is not
//   granted; the other client may take every grant meanwhile.
// Ports: clk, rst (async active-high), bus (alu_share_arb_if.slave).
module alu_share_arb
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_share_arb_if.slave   bus
);

  logic [1:0]         req_valid;
  logic [1:0]         rsp_ready;
  logic [1:0]         rsp_valid;
  logic [1:0]         eligible;
  logic [1:0]         grant;
  alu_req_t [1:0]     req;
  alu_rsp_t [1:0]     rsp;
  alu_req_t           sel;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req[0]    = {bus.req0_a, bus.req0_b, bus.req0_ctrl};
  assign req[1]    = {bus.req1_a, bus.req1_b, bus.req1_ctrl};

  // A slot can take a new result if it is empty or being drained this cycle.
  // Reset masks eligibility so nothing is accepted while rst is held.
  assign eligible = req_valid & (~rsp_valid | rsp_ready) & {2{~rst}};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Idle ALU drive is all zeros so its inputs do not toggle without a grant.
  always_comb begin
    sel = '0;
    if (grant[0]) begin
      sel = req[0];
    end else if (grant[1]) begin
      sel = req[1];
    end
  end

  assign bus.alu_a    = sel.a;
  assign bus.alu_b    = sel.b;
  assign bus.alu_ctrl = sel.ctrl;

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    logic     valid_q;
    alu_rsp_t data_q;
    logic     legal;

    assign legal = alu_ctrl_legal(req[i].ctrl);

    // Capture has priority over drain so a slot can empty and refill on one edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (grant[i]) begin
        valid_q <= 1'b1;
        if (legal) begin
          data_q <= alu_rsp_t'{op: bus.alu_op, zero: bus.alu_zero, err: 1'b0};
        end else begin
          // Illegal opcode: ALU output is meaningless, report a clean zero result.
          data_q <= alu_rsp_t'{op: '0, zero: 1'b1, err: 1'b1};
        end
      end else if (valid_q && rsp_ready[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign rsp_valid[i] = valid_q;
    assign rsp[i]       = data_q;
  end

  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp0_op    = rsp[0].op;
  assign bus.rsp0_zero  = rsp[0].zero;
  assign bus.rsp0_err   = rsp[0].err;

  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp1_op    = rsp[1].op;
  assign bus.rsp1_zero  = rsp[1].zero;
  assign bus.rsp1_err   = rsp[1].err;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a behavioural ALU stub.
// Latency: n/a.
// Backpressure: driven directly through rsp*_ready.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_share_arb_if bus ();

  alu_share_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU stub; unused opcodes return a non-zero marker so the arbiter's
  // override of illegal results is visible.
  always_comb begin
    case (bus.alu_ctrl)
      ALU_ADD:  bus.alu_op = bus.alu_a + bus.alu_b;
      ALU_SUB:  bus.alu_op = bus.alu_a - bus.alu_b;
      ALU_SLL:  bus.alu_op = bus.alu_a << bus.alu_b[4:0];
      ALU_SLT:  bus.alu_op = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      ALU_SLTU: bus.alu_op = {31'd0, bus.alu_a < bus.alu_b};
      ALU_XOR:  bus.alu_op = bus.alu_a ^ bus.alu_b;
      ALU_SRL:  bus.alu_op = bus.alu_a >> bus.alu_b[4:0];
      ALU_SRA:  bus.alu_op = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      ALU_OR:   bus.alu_op = bus.alu_a | bus.alu_b;
      ALU_AND:  bus.alu_op = bus.alu_a & bus.alu_b;
      default:  bus.alu_op = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_zero = (bus.alu_op == '0);

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [3:0] c);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_ctrl  = c;
  endtask

  task automatic drive1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [3:0] c);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_ctrl  = c;
  endtask

  initial begin
    rst = 1'b0;
    drive0(1'b0, '0, '0, 4'h0);
    drive1(1'b0, '0, '0, 4'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state: requests present but nothing accepted, ALU idle.
    #1 rst = 1'b1;
    drive0(1'b1, 32'd5, 32'd7, ALU_SUB);
    drive1(1'b1, 32'd9, 32'd3, ALU_ADD);
    #1;
    chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk("rst_rsp0_op",    bus.rsp0_op, 32'd0);
    chk("rst_rsp0_zero",  bus.rsp0_zero, 1'b0);
    chk("rst_rsp1_err",   bus.rsp1_err, 1'b0);
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    chk("rst_req1_ready", bus.req1_ready, 1'b0);
    chk("rst_alu_a",      bus.alu_a, 32'd0);
    chk("rst_alu_ctrl",   bus.alu_ctrl, 4'h0);
    step();
    step();
    rst = 1'b0;
    drive0(1'b0, '0, '0, 4'h0);
    drive1(1'b0, '0, '0, 4'h0);

    // Single request: add 10 + 20.
    drive0(1'b1, 32'd10, 32'd20, ALU_ADD);
    #1;
    chk("single_req0_ready", bus.req0_ready, 1'b1);
    chk("single_req1_ready", bus.req1_ready, 1'b0);
    chk("single_alu_a",      bus.alu_a, 32'd10);
    chk("single_alu_b",      bus.alu_b, 32'd20);
    step();
    drive0(1'b0, '0, '0, 4'h0);
    #1;
    chk("single_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("single_rsp0_op",    bus.rsp0_op, 32'd30);
    chk("single_rsp0_zero",  bus.rsp0_zero, 1'b0);
    chk("single_rsp0_err",   bus.rsp0_err, 1'b0);
    chk("idle_alu_a",        bus.alu_a, 32'd0);
    chk("idle_alu_ctrl",     bus.alu_ctrl, 4'h0);
    bus.rsp0_ready = 1'b1;
    step();
    chk("single_drained",    bus.rsp0_valid, 1'b0);
    bus.rsp0_ready = 1'b0;

    // Reset pulse so prio is back at 0, then a simultaneous pair.
    rst = 1'b1;
    #1 rst = 1'b0;
    drive0(1'b1, 32'd20, 32'd20, ALU_SUB);
    drive1(1'b1, 32'd1,  32'd2,  ALU_SLL);
    #1;
    chk("pair_req0_ready", bus.req0_ready, 1'b1);
    chk("pair_req1_ready", bus.req1_ready, 1'b0);
    step();
    chk("pair_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("pair_rsp0_op",    bus.rsp0_op, 32'd0);
    chk("pair_rsp0_zero",  bus.rsp0_zero, 1'b1);
    chk("pair_rsp1_empty", bus.rsp1_valid, 1'b0);
    drive0(1'b0, '0, '0, 4'h0);
    #1;
    chk("pair_req1_ready2", bus.req1_ready, 1'b1);
    step();
    drive1(1'b0, '0, '0, 4'h0);
    chk("pair_rsp1_valid", bus.rsp1_valid, 1'b1);
    chk("pair_rsp1_op",    bus.rsp1_op, 32'd4);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    step();
    chk("pair_drain0", bus.rsp0_valid, 1'b0);
    chk("pair_drain1", bus.rsp1_valid, 1'b0);

    // Streaming: both always valid, both drain each cycle; grants alternate 0,1,0,1.
    drive0(1'b1, 32'd1,  32'd1,  ALU_ADD);
    drive1(1'b1, 32'hF0, 32'h0F, ALU_XOR);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stream_req0_ready", bus.req0_ready, (k % 2) == 0);
      chk("stream_req1_ready", bus.req1_ready, (k % 2) == 1);
      step();
      if ((k % 2) == 0) begin
        chk("stream_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("stream_rsp0_op",    bus.rsp0_op, 32'd2);
        chk("stream_rsp1_idle",  bus.rsp1_valid, 1'b0);
      end else begin
        chk("stream_rsp1_valid", bus.rsp1_valid, 1'b1);
        chk("stream_rsp1_op",    bus.rsp1_op, 32'hFF);
        chk("stream_rsp0_idle",  bus.rsp0_valid, 1'b0);
      end
    end
    drive0(1'b0, '0, '0, 4'h0);
    drive1(1'b0, '0, '0, 4'h0);
    step();

    // Backpressure: rsp0 holds srl result while client 1 takes every grant.
    bus.rsp0_ready = 1'b0;
    drive0(1'b1, 32'h8000_0000, 32'd2, ALU_SRL);
    #1;
    chk("bp_first_req0_ready", bus.req0_ready, 1'b1);
    step();
    chk("bp_rsp0_op_first", bus.rsp0_op, 32'h2000_0000);
    drive0(1'b1, 32'd1,  32'd1,  ALU_ADD);
    drive1(1'b1, 32'hFF, 32'h0F, ALU_AND);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
      chk("bp_req1_ready", bus.req1_ready, 1'b1);
      step();
      chk("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("bp_rsp0_op",    bus.rsp0_op, 32'h2000_0000);
      chk("bp_rsp1_op",    bus.rsp1_op, 32'h0F);
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_release_req0_ready", bus.req0_ready, 1'b1);
    chk("bp_release_req1_ready", bus.req1_ready, 1'b0);
    step();
    chk("bp_reload_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("bp_reload_rsp0_op",    bus.rsp0_op, 32'd2);
    chk("bp_rsp1_drained",      bus.rsp1_valid, 1'b0);
    drive0(1'b0, '0, '0, 4'h0);
    drive1(1'b0, '0, '0, 4'h0);
    step();

    // Illegal opcode 1111 on client 1: ALU stub output must be ignored.
    drive1(1'b1, 32'd10, 32'd20, 4'hF);
    #1;
    chk("ill_req1_ready", bus.req1_ready, 1'b1);
    chk("ill_alu_ctrl",   bus.alu_ctrl, 4'hF);
    step();
    drive1(1'b0, '0, '0, 4'h0);
    chk("ill_rsp1_valid", bus.rsp1_valid, 1'b1);
    chk("ill_rsp1_op",    bus.rsp1_op, 32'd0);
    chk("ill_rsp1_zero",  bus.rsp1_zero, 1'b1);
    chk("ill_rsp1_err",   bus.rsp1_err, 1'b1);

    // First illegal encoding 1010 on client 0; rsp1 left unconsumed, prio ends at 1.
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    drive0(1'b1, 32'd1, 32'd1, 4'hA);
    #1;
    chk("ill_a_req0_ready", bus.req0_ready, 1'b1);
    step();
    drive0(1'b0, '0, '0, 4'h0);
    chk("ill_a_rsp0_err",  bus.rsp0_err, 1'b1);
    chk("ill_a_rsp0_op",   bus.rsp0_op, 32'd0);
    chk("ill_a_rsp1_hold", bus.rsp1_valid, 1'b1);

    // Reset between edges: pending responses vanish at once, prio returns to 0.
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk("midrst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("midrst_rsp1_err",   bus.rsp1_err, 1'b0);
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive0(1'b1, 32'hF0, 32'h0F, ALU_OR);
    drive1(1'b1, 32'd5,  32'd3,  ALU_SUB);
    #1;
    chk("postrst_req0_ready", bus.req0_ready, 1'b1);
    chk("postrst_req1_ready", bus.req1_ready, 1'b0);
    step();
    chk("postrst_rsp0_op", bus.rsp0_op, 32'hFF);
    drive0(1'b0, '0, '0, 4'h0);
    #1;
    chk("postrst_req1_ready2", bus.req1_ready, 1'b1);
    step();
    drive1(1'b0, '0, '0, 4'h0);
    chk("postrst_rsp1_op", bus.rsp1_op, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
